// File: rtl/adder_chunked_seq.sv
// adder_chunked_seq
//   Multi-cycle ripple-carry adder/subtractor. WIDTH-bit operands are added
//   CHUNK bits per cycle, LSB chunk first, with the inter-chunk carry held in
//   a register so the critical path is a single CHUNK-bit ripple.
//
//   Ports
//     clk        clock, rising edge
//     rst_n      synchronous active-low reset
//     in_valid   operands present          in_ready   block can accept operands
//     in1, in2   operands A and B          cin        carry in
//     sub        0: A+B+cin, 1: A+~B+cin
//     out_valid  result present            out_ready  consumer takes result
//     sum        low WIDTH bits of result  cout       carry out of MSB
//     ovf        two's-complement signed overflow
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for operands, in_ready=1
//   S_RUN  | adding chunk idx_q each cycle
//   S_DONE | result held on sum/cout/ovf, out_valid=1 until out_ready
module adder_chunked_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LSBW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [LSBW-1:0]  lsb;
  logic [CHUNK:0]   chunk_res;

  // Chunk datapath: one CHUNK-bit add of the current slice plus stored carry.
  // When CHUNK==WIDTH the constant cast folds to 0, matching idx_q which is
  // then always 0.
  always_comb begin
    lsb       = LSBW'(idx_q) * LSBW'(CHUNK);
    chunk_res = {1'b0, a_q[lsb +: CHUNK]} + {1'b0, bx_q[lsb +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      bx_q    <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    bx_d    = bx_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in1;
          bx_d    = sub ? ~in2 : in2;
          carry_d = cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d[lsb +: CHUNK] = chunk_res[CHUNK-1:0];
        carry_d             = chunk_res[CHUNK];
        if (idx_q == LAST_IDX) begin
          // acc_d already holds the final slice, so the result is complete here
          sum_d   = acc_d;
          cout_d  = chunk_res[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == bx_q[WIDTH-1]) &&
                    (acc_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_adder_chunked_seq.sv
module tb_adder_chunked_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, cin, sub;
  logic [31:0] in1, in2;
  int          sel;

  logic        in_valid_w [3];
  logic        out_ready_w[3];
  logic        in_ready_w [3];
  logic        out_valid_w[3];
  logic [31:0] sum_w      [3];
  logic        cout_w     [3];
  logic        ovf_w      [3];

  logic        in_ready_m, out_valid_m, cout_m, ovf_m;
  logic [31:0] sum_m;

  int n_checks = 0;
  int n_pass   = 0;

  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  // Three instances share the operand bus; only the selected one sees handshakes.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      in_valid_w[k]  = in_valid  && (sel == k);
      out_ready_w[k] = out_ready && (sel == k);
    end
    in_ready_m  = in_ready_w[sel];
    out_valid_m = out_valid_w[sel];
    sum_m       = sum_w[sel];
    cout_m      = cout_w[sel];
    ovf_m       = ovf_w[sel];
  end

  adder_chunked_seq #(.WIDTH(32), .CHUNK(8)) dut_c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w[0]), .in_ready(in_ready_w[0]),
    .in1(in1), .in2(in2), .cin(cin), .sub(sub), .out_valid(out_valid_w[0]),
    .out_ready(out_ready_w[0]), .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]));

  adder_chunked_seq #(.WIDTH(32), .CHUNK(32)) dut_c32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w[1]), .in_ready(in_ready_w[1]),
    .in1(in1), .in2(in2), .cin(cin), .sub(sub), .out_valid(out_valid_w[1]),
    .out_ready(out_ready_w[1]), .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]));

  adder_chunked_seq #(.WIDTH(32), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w[2]), .in_ready(in_ready_w[2]),
    .in1(in1), .in2(in2), .cin(cin), .sub(sub), .out_valid(out_valid_w[2]),
    .out_ready(out_ready_w[2]), .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]));

  // Reference: {ovf, cout, sum} of A + Bx + cin
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic s);
    logic [31:0] bx;
    logic [32:0] r;
    logic        v;
    bx = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bx} + {32'd0, c};
    v  = (a[31] == bx[31]) && (r[31] != a[31]);
    return {v, r[32], r[31:0]};
  endfunction

  // Directed vectors with hand-derived expectations
  logic [31:0] t_a   [7] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'hAAAAAAAA,
                             32'h00000005, 32'h80000000, 32'h7FFFFFFF};
  logic [31:0] t_b   [7] = '{32'h00000001, 32'hFFFFFFFF, 32'h55555555, 32'h55555555,
                             32'h00000007, 32'h00000001, 32'hFFFFFFFF};
  logic        t_cin [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic        t_sub [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] t_sum [7] = '{32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,
                             32'hFFFFFFFE, 32'h7FFFFFFF, 32'h80000000};
  logic        t_cout[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic        t_ovf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in1 = '0; in2 = '0; cin = 1'b0; sub = 1'b0; sel = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k; #1;
      n_checks++;
      if (out_valid_m !== 1'b0) $display("FAIL reset_out_valid dut%0d got %b want 0", k, out_valid_m);
      else n_pass++;
      n_checks++;
      if ({ovf_m, cout_m, sum_m} !== 34'd0)
        $display("FAIL reset_result dut%0d got %h want 0", k, {ovf_m, cout_m, sum_m});
      else n_pass++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k; #1;
      n_checks++;
      if (in_ready_m !== 1'b1) $display("FAIL reset_in_ready dut%0d got %b want 1", k, in_ready_m);
      else n_pass++;
    end
    sel = 0;
  endtask

  task automatic test_directed(input int k);
    int          nchunk, lat, w;
    logic [33:0] e;
    sel = k; out_ready = 1'b1;
    nchunk = (k == 0) ? 4 : (k == 1) ? 1 : 32;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      w = 0;
      while (!in_ready_m && w < 100) begin @(negedge clk); w++; end
      if (!in_ready_m) begin
        n_checks++;
        $display("FAIL dir_in_ready_timeout dut%0d vec%0d got 0 want 1", k, i);
      end
      in1 = t_a[i]; in2 = t_b[i]; cin = t_cin[i]; sub = t_sub[i]; in_valid = 1'b1;
      exp_q.push_back({t_ovf[i], t_cout[i], t_sum[i]});
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid_m && lat < 100) begin @(negedge clk); lat++; end
      n_checks++;
      if (lat != nchunk) $display("FAIL dir_latency dut%0d vec%0d got %0d want %0d", k, i, lat, nchunk);
      else n_pass++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL dir_scoreboard_empty dut%0d vec%0d got 0 entries want 1", k, i);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (sum_m !== e[31:0]) $display("FAIL dir_sum dut%0d vec%0d got %h want %h", k, i, sum_m, e[31:0]);
        else n_pass++;
        n_checks++;
        if (cout_m !== e[32]) $display("FAIL dir_cout dut%0d vec%0d got %b want %b", k, i, cout_m, e[32]);
        else n_pass++;
        n_checks++;
        if (ovf_m !== e[33]) $display("FAIL dir_ovf dut%0d vec%0d got %b want %b", k, i, ovf_m, e[33]);
        else n_pass++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [33:0] e;
    sel = 0; out_ready = 1'b0;
    @(negedge clk);
    in1 = 32'h12345678; in2 = 32'h11111111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'h23456789});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid_m && lat < 100) begin @(negedge clk); lat++; end
    e = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (out_valid_m !== 1'b1) $display("FAIL bp_out_valid cycle%0d got %b want 1", c, out_valid_m);
      else n_pass++;
      n_checks++;
      if ({cout_m, sum_m} !== e[32:0]) $display("FAIL bp_hold cycle%0d got %h want %h", c, {cout_m, sum_m}, e[32:0]);
      else n_pass++;
      n_checks++;
      if (in_ready_m !== 1'b0) $display("FAIL bp_in_ready cycle%0d got %b want 0", c, in_ready_m);
      else n_pass++;
      in_valid = c[0] ? 1'b0 : 1'b1;
      in1 = 32'hDEAD0000 + c; in2 = 32'h0BAD0000; cin = 1'b1; sub = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1)
      $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", out_valid_m, in_ready_m);
    else n_pass++;
    in1 = 32'h00000001; in2 = 32'h00000002; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'h00000003});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid_m && lat < 100) begin @(negedge clk); lat++; end
    e = exp_q.pop_front();
    n_checks++;
    if ({ovf_m, cout_m, sum_m} !== e) $display("FAIL bp_next_op got %h want %h", {ovf_m, cout_m, sum_m}, e);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int          lat;
    logic [33:0] e;
    bit          ghost;
    sel = 0; out_ready = 1'b1;
    @(negedge clk);
    in1 = 32'h80000000; in2 = 32'h00000001; cin = 1'b1; sub = 1'b1; in_valid = 1'b1;
    exp_q.push_back({1'b1, 1'b1, 32'h7FFFFFFF});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid_m && lat < 100) begin @(negedge clk); lat++; end
    e = exp_q.pop_front();
    n_checks++;
    if ({ovf_m, cout_m, sum_m} !== e) $display("FAIL rst_pre_op got %h want %h", {ovf_m, cout_m, sum_m}, e);
    else n_pass++;
    @(negedge clk);
    // aborted op: never pushed to the scoreboard
    in1 = 32'hFFFF0000; in2 = 32'h0000FFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid_m !== 1'b0) $display("FAIL rst_mid_out_valid got %b want 0", out_valid_m);
    else n_pass++;
    n_checks++;
    if ({ovf_m, cout_m, sum_m} !== 34'd0) $display("FAIL rst_mid_result got %h want 0", {ovf_m, cout_m, sum_m});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready_m !== 1'b1) $display("FAIL rst_mid_in_ready got %b want 1", in_ready_m);
    else n_pass++;
    ghost = 1'b0;
    repeat (40) begin
      if (out_valid_m) ghost = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (ghost) $display("FAIL rst_mid_ghost got out_valid=1 want no output");
    else n_pass++;
  endtask

  task automatic test_random();
    int          sent, got, cyc, nops;
    logic [33:0] e, act;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      nops = (k == 2) ? 332 : 334;
      sent = 0; got = 0; cyc = 0;
      while (got < nops && cyc < 30000) begin
        @(negedge clk);
        cyc++;
        in_valid  = (sent < nops) && ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        in1 = $urandom; in2 = $urandom;
        if ($urandom_range(0, 7) == 0) in1 = 32'hFFFFFFFF;
        if ($urandom_range(0, 7) == 0) in2 = 32'h80000000;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        #1;
        if (in_valid && in_ready_m) begin
          exp_q.push_back(model(in1, in2, cin, sub));
          sent++;
        end
        if (out_valid_m && out_ready) begin
          act = {ovf_m, cout_m, sum_m};
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL rand_unexpected dut%0d got %h want no output", k, act);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) $display("FAIL rand_result dut%0d op%0d got %h want %h", k, got, act, e);
            else n_pass++;
          end
          got++;
        end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      if (got < nops) begin
        n_checks++;
        $display("FAIL rand_timeout dut%0d got %0d results want %0d", k, got, nops);
      end
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed(0);
    test_directed(1);
    test_directed(2);
    test_backpressure();
    test_reset_mid_run();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
